// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, field positions and codes for the unsigned divider
package divider_pkg;

  // Operand/result width; the 8-bit pin frame holds exactly two fields.
  localparam int DW = 4;

  // Result code driven when the divisor is zero (Q = 4'hF, R = 4'hF).
  localparam logic [2*DW-1:0] DIV0_CODE = 8'hFF;

  // Input packing: dividend in the high nibble, divisor in the low nibble.
  localparam int A_MSB = 7;
  localparam int A_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  // Output packing: quotient in the high nibble, remainder in the low nibble.
  localparam int Q_MSB = 7;
  localparam int Q_LSB = 4;
  localparam int R_MSB = 3;
  localparam int R_LSB = 0;

  typedef logic [DW-1:0]   nibble_t;
  typedef logic [2*DW-1:0] frame_t;

  // Core result bundle.
  typedef struct packed {
    nibble_t q;
    nibble_t r;
    logic    div0;
  } div_result_t;

  // Packs quotient and remainder into the output frame.
  function automatic frame_t pack_result(input nibble_t q, input nibble_t r);
    frame_t f;
    f = '0;
    f[Q_MSB:Q_LSB] = q;
    f[R_MSB:R_LSB] = r;
    return f;
  endfunction

  // Extracts the dividend from the input frame.
  function automatic nibble_t get_dividend(input frame_t f);
    return f[A_MSB:A_LSB];
  endfunction

  // Extracts the divisor from the input frame.
  function automatic nibble_t get_divisor(input frame_t f);
    return f[B_MSB:B_LSB];
  endfunction

endpackage

// File: rtl/unsigned_divider_if.sv
// rtl/unsigned_divider_if.sv - pin-frame bundle between the divider and its driver
interface unsigned_divider_if;
  import divider_pkg::*;

  logic   ena;
  frame_t ui_in;
  frame_t uo_out;
  frame_t uio_in;
  frame_t uio_out;
  frame_t uio_oe;

  // Driver side: supplies enable and operands, observes results.
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // Divider side.
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/udiv_core.sv
// rtl/udiv_core.sv - combinational 4-stage restoring divider array
module udiv_core
  import divider_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  output nibble_t q,
  output nibble_t r,
  output logic    div0
);

  // Partial remainder carries one extra bit so the trial difference can
  // show a borrow in its top bit.
  logic [DW:0] part_rem;
  logic [DW:0] trial;
  nibble_t     q_bits;

  // One shift-and-trial-subtract per quotient bit, MSB first; restore on borrow.
  always_comb begin
    part_rem = '0;
    trial    = '0;
    q_bits   = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      part_rem = {part_rem[DW-1:0], a[i]};
      trial    = part_rem - {1'b0, b};
      if (!trial[DW]) begin
        part_rem  = trial;
        q_bits[i] = 1'b1;
      end
    end
  end

  // The remainder is always below the divisor after the last stage, so its
  // top bit is zero and only the low DW bits are meaningful.
  assign q    = q_bits;
  assign r    = part_rem[DW-1:0];
  assign div0 = (b == '0);

  logic unused_rem_msb;
  assign unused_rem_msb = part_rem[DW];

endmodule

// File: rtl/unsigned_divider.sv
// rtl/unsigned_divider.sv - registered 4-bit unsigned divider in the pin frame
module unsigned_divider
  import divider_pkg::*;
(
  input logic               clk,
  input logic               rst,
  unsigned_divider_if.slave bus
);

  nibble_t core_q;
  nibble_t core_r;
  logic    core_div0;
  frame_t  next_result;
  frame_t  result_q;

  udiv_core u_core (
    .a    (get_dividend(bus.ui_in)),
    .b    (get_divisor(bus.ui_in)),
    .q    (core_q),
    .r    (core_r),
    .div0 (core_div0)
  );

  // Divide-by-zero overrides whatever the array produced.
  always_comb begin
    next_result = pack_result(core_q, core_r);
    if (core_div0) begin
      next_result = DIV0_CODE;
    end
  end

  // Output register: reset wins, otherwise load only while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (bus.ena) begin
      result_q <= next_result;
    end
  end

  assign bus.uo_out  = result_q;
  assign bus.uio_out = '0;
  assign bus.uio_oe  = '0;

  logic unused_uio;
  assign unused_uio = ^bus.uio_in;

endmodule

// File: tb/tb_unsigned_divider.sv
// tb/tb_unsigned_divider.sv - directed self-checking bench for unsigned_divider
module tb_unsigned_divider;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  unsigned_divider_if tb_bus ();

  unsigned_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at the falling edge, pass one rising edge, sample 1 time unit later.
  task automatic step(input logic [7:0] ui, input logic en, input logic r);
    @(negedge clk);
    tb_bus.ui_in  = ui;
    tb_bus.ena    = en;
    tb_bus.uio_in = 8'($urandom);
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (tb_bus.uo_out === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, tb_bus.uo_out, exp);
    end
    total++;
    assert (tb_bus.uio_out === 8'h00 && tb_bus.uio_oe === 8'h00)
    else begin
      bad++;
      $error("FAIL %s_static observed=%h/%h expected=00/00", tag, tb_bus.uio_out, tb_bus.uio_oe);
    end
  endtask

  initial begin
    logic [7:0] exp;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    tb_bus.ena    = 1'b1;
    tb_bus.ui_in  = 8'h00;
    tb_bus.uio_in = 8'h00;

    step(8'h53, 1'b1, 1'b1);
    check("reset", 8'h00);
    step(8'h53, 1'b1, 1'b0);
    check("after_reset_5div3", 8'h12);

    step(8'hF4, 1'b1, 1'b0);
    check("15div4", 8'h33);
    step(8'h72, 1'b1, 1'b0);
    check("7div2", 8'h31);
    step(8'h3B, 1'b1, 1'b0);
    check("3div11", 8'h03);
    step(8'hFF, 1'b1, 1'b0);
    check("15div15", 8'h10);
    step(8'h01, 1'b1, 1'b0);
    check("0div1", 8'h00);
    step(8'hD1, 1'b1, 1'b0);
    check("13div1", 8'hD0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        step({4'(a), 4'(b)}, 1'b1, 1'b0);
        exp = {4'(a / b), 4'(a % b)};
        check("sweep", exp);
      end
    end

    step(8'h50, 1'b1, 1'b0);
    check("div0_5", 8'hFF);
    step(8'h00, 1'b1, 1'b0);
    check("div0_0", 8'hFF);
    step(8'hF0, 1'b1, 1'b0);
    check("div0_15", 8'hFF);

    step(8'hF4, 1'b1, 1'b0);
    check("hold_load", 8'h33);
    step(8'h72, 1'b0, 1'b0);
    check("hold_1", 8'h33);
    step(8'h72, 1'b0, 1'b0);
    check("hold_2", 8'h33);
    step(8'h72, 1'b1, 1'b0);
    check("hold_release", 8'h31);

    for (int k = 0; k < 4; k++) begin
      step(8'h50, 1'b1, 1'b0);
      check("b2b_div0", 8'hFF);
      step(8'h95, 1'b1, 1'b0);
      check("b2b_9div5", 8'h14);
    end

    step(8'hF4, 1'b0, 1'b1);
    check("reset_over_ena0", 8'h00);
    step(8'hF4, 1'b1, 1'b0);
    check("reload", 8'h33);
    step(8'h72, 1'b1, 1'b1);
    check("reset_mid_op", 8'h00);
    step(8'h72, 1'b0, 1'b0);
    check("hold_after_reset", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unsigned_divider.md
Name: unsigned_divider

Overview:
- 4-bit unsigned integer divider in the Tiny Tapeout user-module pin frame.
- ui_in packs the dividend and divisor. uo_out returns the quotient and remainder, registered, one clock after the operands are presented.
- Divide-by-zero returns the saturated code 8'hFF.
- Bidirectional pins are unused and held as inputs.

Parameters:
- DW, 4, operand/result width. Only 4 is supported, because the pin packing fixes 2*DW = 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  design enable; the output register updates only when ena=1.
- ui_in  input  8  [7:4] dividend A, [3:0] divisor B, both unsigned.
- uo_out  output  8  [7:4] quotient Q, [3:0] remainder R (registered).
- uio_in  input  8  unused, ignored.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Reset:
  - On a rising clk edge with rst=1, the uo_out register becomes 8'h00.
  - Reset has priority over ena and over the operands.
  - Reset asserted mid-operation discards the pending result.
- Normal operation (rst=0, ena=1), at each rising edge with the current ui_in:
  - If B != 0: uo_out <= {A / B, A % B}, with truncating unsigned division, so Q*B + R = A and R < B.
  - If B == 0: uo_out <= 8'hFF (Q = 4'hF, R = 4'hF), regardless of A.
- Hold: when ena=0 and rst=0, uo_out holds its previous value.
- Latency and throughput:
  - Latency is exactly one clock: operands stable before edge k appear on uo_out after edge k.
  - A new operand pair is accepted every cycle; there is no handshake and no busy state.
- Divide core:
  - Purely combinational 4-stage restoring divider, one trial subtraction per quotient bit, MSB first.
  - Partial remainder is 5 bits wide to hold the borrow. Quotient bit is 1 when the trial difference is non-negative.
  - Core outputs Q[3:0] and R[3:0]; the divide-by-zero override is applied after the core.
- Boundary values:
  - A=0 gives Q=0, R=0 for any B != 0.
  - B=1 gives Q=A, R=0.
  - A<B gives Q=0, R=A.
  - A=B gives Q=1, R=0.
  - A=15, B=15 gives 8'h10.
  - A=0, B=0 gives 8'hFF (the divide-by-zero rule wins).
- uio_out and uio_oe are tied to 0 and are unaffected by reset or ena.
- No X propagation: all outputs are defined from the first reset onward.

Decomposition:
- Shared package (divider_pkg):
  - DW = 4.
  - DIV0_CODE = 8'hFF.
  - Field positions: dividend [7:4], divisor [3:0]; quotient [7:4], remainder [3:0].
- Sub-module udiv_core:
  - Combinational restoring array, inputs a[DW-1:0], b[DW-1:0]; outputs q, r, div0 flag.
- Top level: instantiates udiv_core, muxes in DIV0_CODE, holds the output register with reset/enable, and ties off the uio pins.

Test Plan:
- Reset: rst=1 for one edge with ui_in=8'h53 -> uo_out=8'h00. Release rst -> the next edge shows 8'h12 (5/3: Q=1, R=2).
- Exhaustive sweep:
  - All A in 0..15 and B in 1..15, one pair per cycle with ena=1.
  - Each pair -> {A/B, A%B} one cycle later, e.g. 8'hF4 -> 8'h33, 8'h72 -> 8'h31, 8'h3B -> 8'h03.
- Divide-by-zero: ui_in=8'h50 -> uo_out=8'hFF. Also ui_in=8'h00 -> 8'hFF, and 8'hF0 -> 8'hFF.
- Enable hold: load 8'hF4 (result 8'h33), then drop ena and apply 8'h72 -> uo_out stays 8'h33. Raise ena -> 8'h31 after one edge.
- Back-to-back: alternate 8'h50 and 8'h95 on consecutive cycles -> uo_out alternates 8'hFF and 8'h14 with no bubbles.
- Static pins: at all times uio_out=8'h00 and uio_oe=8'h00, and uio_in toggling has no effect on uo_out.
